// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   I2S master transmitter. Left/right 24-bit PCM strobes are paired into
//   stereo samples and buffered in a small FIFO. The block generates
//   bclk/lrclk from clk and shifts out standard I2S: 32-bit slots, MSB
//   first, with data delayed one bclk after each lrclk edge.
//
// Ports
//   clk, reset_n     system clock, synchronous active-low reset
//   run              enable; low forces IDLE and flushes the FIFO
//   status_clr       clears the sticky status bits [2:0]
//   l_data_en/l_data left sample strobe and data
//   r_data_en/r_data right sample strobe and data; a right strobe pushes a pair
//   bclk, lrclk      I2S bit clock and word select (0 = left)
//   s_data           I2S serial data, changes on bclk falling edges only
//   frame_stb        one-clk pulse whenever a frame is loaded
//   status           [0] underflow, [1] overflow, [2] pair_err,
//                    [5:3] fifo level, [7:6] state (0 IDLE, 1 PRIME, 2 RUN)
//
// The sample strobes carry no backpressure: a strobe is taken in the cycle
// it is high. A pair that finds the FIFO full is dropped and reported as
// overflow.
//
// FIFO_DEPTH must be a power of two and at least 2.

module i2s_tx_serializer #(
  parameter int BCLK_DIV    = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRIME_LEVEL = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        status_clr,
  input  logic        l_data_en,
  input  logic        r_data_en,
  input  logic [23:0] l_data,
  input  logic [23:0] r_data,
  output logic        bclk,
  output logic        lrclk,
  output logic        s_data,
  output logic        frame_stb,
  output logic [7:0]  status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [63:0]   frame;
  logic [23:0]   l_hold;
  logic          l_pending;
  logic          underflow, overflow, pair_err;

  logic [47:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          start, tick, wrap, running;
  logic [5:0]    bit_nxt, tx_idx;
  logic          fifo_empty, fifo_full;
  logic          pop_evt, do_pop, do_push, push_req;
  logic          underflow_evt, overflow_evt, pair_evt;
  logic [47:0]   push_pair, pop_pair;
  logic [63:0]   pop_frame;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    tick    = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_PRIME;
      ST_PRIME: if (count >= CW'(PRIME_LEVEL)) begin
        state_d = ST_RUN;
        start   = 1'b1;
      end
      ST_RUN: begin
        tick = (div_cnt == DIV_LAST);
        // Falling bclk edge that rolls bit_cnt over to 0 starts a new frame.
        wrap = tick && bclk && (bit_nxt == 6'd0);
      end
      default: state_d = ST_IDLE;
    endcase
    if (!run) begin
      state_d = ST_IDLE;
      start   = 1'b0;
      tick    = 1'b0;
      wrap    = 1'b0;
    end
  end

  assign running = run && (state_q == ST_RUN);
  assign bit_nxt = bit_cnt + 6'd1;
  // 64 - n in six bits; only used for n = 1..63.
  assign tx_idx  = 6'd0 - bit_nxt;

  // ---------------------------------------------------------- pairing/FIFO
  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == CW'(FIFO_DEPTH));
  assign pop_evt       = start || wrap;
  assign do_pop        = pop_evt && !fifo_empty;
  assign underflow_evt = pop_evt && fifo_empty;
  assign push_req      = run && r_data_en;
  // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
  assign do_push       = push_req && (!fifo_full || do_pop);
  assign overflow_evt  = push_req && !do_push;
  assign pair_evt      = r_data_en && !l_data_en && !l_pending;
  assign push_pair     = {(l_data_en ? l_data : l_hold), r_data};
  assign pop_pair      = fifo_mem[rd_ptr];
  // An empty pop loads silence.
  assign pop_frame     = do_pop ? {pop_pair[47:24], 8'h00, pop_pair[23:0], 8'h00}
                                : 64'h0;

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_pair;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      l_hold    <= '0;
      l_pending <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      pair_err  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (l_data_en) l_hold <= l_data;
      if (r_data_en)      l_pending <= 1'b0;
      else if (l_data_en) l_pending <= 1'b1;

      // Set events take priority over a clear in the same cycle.
      if (underflow_evt)   underflow <= 1'b1;
      else if (status_clr) underflow <= 1'b0;
      if (overflow_evt)    overflow  <= 1'b1;
      else if (status_clr) overflow  <= 1'b0;
      if (pair_evt)        pair_err  <= 1'b1;
      else if (status_clr) pair_err  <= 1'b0;

      if (!run) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  // ------------------------------------------------------------ serializer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      s_data    <= 1'b0;
      frame_stb <= 1'b0;
      frame     <= '0;
    end else begin
      frame_stb <= 1'b0;
      if (start) begin
        div_cnt   <= '0;
        bit_cnt   <= '0;
        bclk      <= 1'b0;
        lrclk     <= 1'b0;
        s_data    <= 1'b0;
        frame     <= pop_frame;
        frame_stb <= 1'b1;
      end else if (running) begin
        if (tick) begin
          div_cnt <= '0;
          bclk    <= ~bclk;
          // Only the falling edge moves data; the rising edge is for sampling.
          if (bclk) begin
            bit_cnt <= bit_nxt;
            lrclk   <= bit_nxt[5];
            if (bit_nxt == 6'd0) begin
              frame     <= pop_frame;
              frame_stb <= 1'b1;
              s_data    <= 1'b0;
            end else begin
              s_data <= frame[tx_idx];
            end
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk    <= 1'b0;
        lrclk   <= 1'b0;
        s_data  <= 1'b0;
      end
    end
  end

  assign status = {state_q, 3'(count), pair_err, overflow, underflow};

endmodule
